// File: rtl/boot_copier.sv
// Boot copier: streams boot ROM words into RAM through a valid/ready write
// port, then releases the CPU from reset.
module boot_copier #(
  parameter int          ADDR_W     = 8,
  parameter int          WORDS      = 256,
  parameter logic [15:0] RAM_BASE   = 16'h0000,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [15:0]       ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  input  logic              ram_ready,
  output logic              busy,
  output logic              done,
  output logic              cpu_rst_n
);

  localparam int IW = ADDR_W + 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WRITE,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [15:0]   hold;
  logic          arm;

  // Address and data are pure decodes of registered state.
  assign rom_addr  = idx[ADDR_W-1:0];
  assign ram_addr  = RAM_BASE + 16'(idx);
  assign ram_wdata = hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      hold      <= '0;
      arm       <= AUTO_START;
      ram_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cpu_rst_n <= 1'b0;
    end else begin
      arm <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start || arm) begin
            state <= FETCH;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          hold   <= rom_data;
          state  <= WRITE;
          ram_we <= 1'b1;
        end
        WRITE: begin
          if (ram_ready) begin
            ram_we <= 1'b0;
            if (idx == LAST) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          if (start) begin
            state     <= FETCH;
            idx       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            cpu_rst_n <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
